// File: rtl/bpsk_frame_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bpsk_frame_sync
//
// Frame synchroniser for a hard-decision BPSK bit stream. Hunts for a 16-bit
// sync word in either polarity, so the 180-degree carrier phase ambiguity is
// resolved. Once locked, it assembles a fixed number of payload bytes and then
// re-checks the sync word that follows. A flywheel tolerates up to
// MISS_LIMIT-1 consecutive bad sync words before it drops back to hunting.
//
// Parameters
//   SYNC_WORD      sync pattern, MSB first on air
//   MAX_ERR        bit mismatches tolerated in a sync match (0..7)
//   PAYLOAD_BYTES  payload bytes between successive sync words
//   MISS_LIMIT     consecutive failed sync checks that drop lock
//
// Ports
//   clk_16M384   in   single clock, rising edge
//   rst_16M384   in   synchronous active-high reset
//   bit_in       in   hard-decision demodulated bit
//   bit_vld      in   qualifies bit_in (at most one cycle in 16)
//   byte_out     out  recovered payload byte, MSB = first received bit
//   byte_vld     out  one-cycle strobe qualifying byte_out
//   frame_start  out  with byte_vld on the first payload byte of a frame
//   locked       out  high while in PAYLOAD or VERIFY
//   inverted     out  lock was acquired on ~SYNC_WORD
// -----------------------------------------------------------------------------
module bpsk_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int unsigned MAX_ERR       = 1,
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned MISS_LIMIT    = 3
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       frame_start,
  output logic       locked,
  output logic       inverted
);

  localparam int BYTE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PAYLOAD_BYTES - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [4:0]        ERR_MAX   = 5'(MAX_ERR);
  localparam logic [4:0]        FILL_FULL = 5'd16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    VERIFY  = 2'd2
  } state_t;

  // Number of differing bits between two 16-bit words.
  function automatic logic [4:0] hamming16(input logic [15:0] a,
                                           input logic [15:0] b);
    logic [15:0] x;
    logic [4:0]  n;
    x = a ^ b;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, x[i]};
    end
    return n;
  endfunction

  // Window fill count, saturating once the window holds 16 valid bits.
  function automatic logic [4:0] sat_fill(input logic [4:0] f);
    return (f >= FILL_FULL) ? FILL_FULL : f + 5'd1;
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        win_q, win_d;
  logic [4:0]         fill_q, fill_d;
  logic [3:0]         vcnt_q, vcnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [7:0]         asm_q, asm_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic               byte_vld_q, byte_vld_d;
  logic               frame_start_q, frame_start_d;
  logic               inverted_q, inverted_d;

  logic [15:0]        win_shift;
  logic [4:0]         fill_inc;
  logic [4:0]         dist_n;
  logic [4:0]         dist_i;
  logic [4:0]         dist_v;
  logic               data_bit;
  logic [7:0]         asm_shift;
  logic [MISS_W-1:0]  miss_inc;

  // The window always includes the bit being accepted this cycle, so a match
  // is recognised on the same edge that shifts in the last sync bit.
  assign win_shift = {win_q[14:0], bit_in};
  assign fill_inc  = sat_fill(fill_q);
  assign dist_n    = hamming16(win_shift, SYNC_WORD);
  assign dist_i    = hamming16(win_shift, ~SYNC_WORD);
  // VERIFY only accepts the polarity locked in HUNT; the opposite one is a miss.
  assign dist_v    = inverted_q ? dist_i : dist_n;
  assign data_bit  = bit_in ^ inverted_q;
  assign asm_shift = {asm_q[6:0], data_bit};
  // Never evaluated with miss_q == MISS_MAX: reaching it leaves VERIFY for HUNT
  // and HUNT clears it on the way back into PAYLOAD.
  assign miss_inc  = miss_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    fill_d        = fill_q;
    vcnt_d        = vcnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    miss_d        = miss_q;
    asm_d         = asm_q;
    byte_out_d    = byte_out_q;
    byte_vld_d    = 1'b0;
    frame_start_d = 1'b0;
    inverted_d    = inverted_q;

    if (bit_vld) begin
      unique case (state_q)
        HUNT: begin
          win_d  = win_shift;
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL) begin
            // Normal polarity wins when both distances are within tolerance.
            if (dist_n <= ERR_MAX) begin
              state_d    = PAYLOAD;
              inverted_d = 1'b0;
              miss_d     = '0;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
              asm_d      = '0;
            end else if (dist_i <= ERR_MAX) begin
              state_d    = PAYLOAD;
              inverted_d = 1'b1;
              miss_d     = '0;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
              asm_d      = '0;
            end
          end
        end

        PAYLOAD: begin
          asm_d = asm_shift;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d     = '0;
            byte_out_d    = asm_shift;
            byte_vld_d    = 1'b1;
            frame_start_d = (byte_cnt_q == '0);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              vcnt_d     = '0;
              state_d    = VERIFY;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end

        VERIFY: begin
          win_d = win_shift;
          if (vcnt_q == 4'd15) begin
            vcnt_d    = '0;
            bit_cnt_d = '0;
            if (dist_v <= ERR_MAX) begin
              miss_d  = '0;
              state_d = PAYLOAD;
            end else if (miss_inc == MISS_MAX) begin
              // Drop lock. The closing bit is not kept as a hunt fill bit, so
              // the hunt restarts from an empty window.
              miss_d     = miss_inc;
              state_d    = HUNT;
              win_d      = '0;
              fill_d     = '0;
              inverted_d = 1'b0;
            end else begin
              // Flywheel: trust the frame timing and keep delivering payload.
              miss_d  = miss_inc;
              state_d = PAYLOAD;
            end
          end else begin
            vcnt_d = vcnt_q + 4'd1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      state_q       <= HUNT;
      win_q         <= '0;
      fill_q        <= '0;
      vcnt_q        <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      miss_q        <= '0;
      asm_q         <= '0;
      byte_out_q    <= '0;
      byte_vld_q    <= 1'b0;
      frame_start_q <= 1'b0;
      inverted_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      vcnt_q        <= vcnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      miss_q        <= miss_d;
      asm_q         <= asm_d;
      byte_out_q    <= byte_out_d;
      byte_vld_q    <= byte_vld_d;
      frame_start_q <= frame_start_d;
      inverted_q    <= inverted_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_vld    = byte_vld_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q != HUNT);
  assign inverted    = inverted_q;

endmodule

// File: doc/bpsk_frame_sync.md
BPSK_FRAME_SYNC -- requirements
Module: bpsk_frame_sync

Interface
- REQ-001: The module SHALL have parameter SYNC_WORD, default 16'hEB90: sync pattern, MSB first on air.
- REQ-002: The module SHALL have parameter MAX_ERR, default 1: maximum tolerated bit mismatches in a sync match; legal values are 0 to 7.
- REQ-003: The module SHALL have parameter PAYLOAD_BYTES, default 8: payload bytes between successive sync words.
- REQ-004: The module SHALL have parameter MISS_LIMIT, default 3: number of consecutive failed sync checks that drops lock.
- REQ-005: Port clk_16M384, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
- REQ-006: Port rst_16M384, input, 1 bit: reset, synchronous and active-high.
- REQ-007: Port bit_in, input, 1 bit: hard-decision demodulated BPSK bit.
- REQ-008: Port bit_vld, input, 1 bit: bit_in SHALL be accepted only on cycles where bit_vld=1; it is asserted at most one cycle in any 16.
- REQ-009: Port byte_out, output, 8 bits: recovered payload byte, MSB = first received bit.
- REQ-010: Port byte_vld, output, 1 bit: one-cycle strobe qualifying byte_out.
- REQ-011: Port frame_start, output, 1 bit: asserted together with byte_vld on the first payload byte of each frame.
- REQ-012: Port locked, output, 1 bit: high while in states PAYLOAD or VERIFY.
- REQ-013: Port inverted, output, 1 bit: 1 when lock was acquired on ~SYNC_WORD, i.e. 180-degree phase ambiguity.

Function
- REQ-014: The FSM SHALL have exactly three states: HUNT, PAYLOAD, VERIFY.
- REQ-015: HUNT SHALL shift accepted bits into a 16-bit window and count fill bits, saturating at 16.
- REQ-016: HUNT SHALL evaluate a match only when fill = 16, including the bit accepted on the current cycle.
- REQ-017: HUNT SHALL compute the Hamming distance of the window to SYNC_WORD (dN) and to ~SYNC_WORD (dI) on each accepted bit.
- REQ-018: If dN <= MAX_ERR, the FSM SHALL go to PAYLOAD with inverted<=0; else if dI <= MAX_ERR, it SHALL go to PAYLOAD with inverted<=1.
- REQ-019: The normal-polarity match SHALL take priority over the inverted match.
- REQ-020: On entering PAYLOAD from HUNT, the miss counter SHALL be cleared.
- REQ-021: PAYLOAD SHALL assemble accepted bits XOR inverted, MSB first, into bytes.
- REQ-022: On the cycle after the edge accepting the 8th bit of a byte, byte_out SHALL be valid and byte_vld SHALL be 1 for exactly one cycle, giving a latency of 1 clock.
- REQ-023: byte_out SHALL hold its value until the next byte_vld.
- REQ-024: frame_start SHALL be 1 only with byte_vld for byte index 0.
- REQ-025: After PAYLOAD_BYTES bytes, the FSM SHALL go to VERIFY.
- REQ-026: VERIFY SHALL collect 16 accepted bits and compare them against SYNC_WORD XOR {16{inverted}} using the same MAX_ERR rule.
- REQ-027: On a VERIFY pass, the miss counter SHALL be cleared and the FSM SHALL go to PAYLOAD.
- REQ-028: On a VERIFY fail, the miss counter SHALL be incremented. If it then equals MISS_LIMIT, the FSM SHALL go to HUNT; otherwise it SHALL go to PAYLOAD (flywheel).
- REQ-029: A VERIFY that matches the opposite polarity SHALL count as a fail; polarity SHALL change only via HUNT.
- REQ-030: Entering HUNT from VERIFY SHALL clear the window, fill count, and inverted.
- REQ-031: Entering HUNT from VERIFY SHALL let locked fall on the same edge as the state change.
- REQ-032: The bit that completes the final failing VERIFY SHALL NOT be counted as a HUNT fill bit.
- REQ-033: Cycles with bit_vld=0 SHALL leave the state, counters, and window unchanged.
- REQ-034: byte_vld and frame_start SHALL be 0 whenever no byte completes.
- REQ-035: Each counter SHALL be sized for its parameter range, with no wrap in normal use.
- REQ-036: The miss counter SHALL never exceed MISS_LIMIT.

Reset
- REQ-037: With rst_16M384=1 at a rising edge, the next state SHALL be HUNT.
- REQ-038: The same reset SHALL clear the window, fill count, bit/byte/miss counters, byte_out, byte_vld, frame_start, locked, and inverted to 0.
- REQ-039: Reset SHALL take priority over bit_vld, including mid-byte and mid-VERIFY; a partial byte SHALL be discarded and never output.

Verification
- REQ-040: Bench scenario: stream 0xEB90 followed by payload 01 02 .. 08 with bit_vld every 16th cycle -> locked=1 and inverted=0 after the 16th sync bit; eight byte_vld pulses give 01..08, each one cycle after its 8th bit; frame_start with 01 only.
- REQ-041: Bench scenario: the same stream fully bit-inverted -> inverted=1; bytes still 01..08.
- REQ-042: Bench scenario: sync with 1 bit flipped (0xEB91) -> lock; with 2 bits flipped (0xEB93) -> no lock and no byte_vld.
- REQ-043: Bench scenario: lock, then replace three consecutive sync words with 0x0000 -> payload continues through misses 1 and 2; locked falls at the end of the 3rd VERIFY; no byte_vld afterwards until a fresh 0xEB90 is received.
- REQ-044: Bench scenario: lock, one bad sync, then a good sync -> miss counter back to 0; a further two bad syncs keep locked=1.
- REQ-045: Bench scenario: assert rst_16M384 after 5 bits of a payload byte -> all outputs 0 the next cycle; a fresh frame relocks and its first byte carries frame_start=1.
